// File: rtl/bf16_block_gather_if.sv
// Stream-in / block-out bundle for bf16_block_gather.
// Valid/ready: a transfer happens on a posedge where valid & ready are both 1; a source holds its payload stable while valid & ~ready.
interface bf16_block_gather_if #(
    parameter int NUM           = 10,
    parameter int LANES         = 2,
    parameter int EXPONENT_SIZE = 8,
    parameter int MANTISSA_SIZE = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic [16*LANES-1:0]      in_data;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic                     sign_out     [0:NUM-1];
    logic [EXPONENT_SIZE-1:0] exponent_out [0:NUM-1];
    logic [MANTISSA_SIZE-1:0] mantissa_out [0:NUM-1];

    // master: the gather block itself; slave: the side feeding beats and taking blocks.
    modport master (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, sign_out, exponent_out, mantissa_out
    );
    modport slave (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, sign_out, exponent_out, mantissa_out
    );
endinterface

// File: rtl/bf16_block_gather.sv
// Gathers LANES-wide bf16 beats into NUM-element blocks split into sign/exponent/mantissa.
// Optional BF16_GATHER_SAT_EN: inf/NaN saturate to exponent 0xFE, mantissa all-ones.
module bf16_block_gather #(
    parameter int NUM           = 10,
    parameter int LANES         = 2,
    parameter int EXPONENT_SIZE = 8,
    parameter int MANTISSA_SIZE = 8,
    localparam int BEATS        = (NUM + LANES - 1) / LANES,
    localparam int CNT_W        = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    bf16_block_gather_if.master  bus,
    output logic [CNT_W-1:0]     beat_cnt
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    logic                     dec_sign [LANES];
    logic [EXPONENT_SIZE-1:0] dec_exp  [LANES];
    logic [MANTISSA_SIZE-1:0] dec_mant [LANES];

    logic                     asm_sign [0:NUM-1];
    logic [EXPONENT_SIZE-1:0] asm_exp  [0:NUM-1];
    logic [MANTISSA_SIZE-1:0] asm_mant [0:NUM-1];

    logic accept;
    logic completing;

    // in_last can close the block early, so a stalled output only blocks beats that would complete.
    assign bus.in_ready = ~bus.out_valid | bus.out_ready | ((beat_cnt != LAST_BEAT) & ~bus.in_last);
    assign accept       = bus.in_valid & bus.in_ready;
    assign completing   = accept & ((beat_cnt == LAST_BEAT) | bus.in_last);

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            dec_sign[l] = bus.in_data[16*l+15];
            dec_exp[l]  = EXPONENT_SIZE'(bus.in_data[16*l+7 +: 8]);
            dec_mant[l] = MANTISSA_SIZE'({1'b1, bus.in_data[16*l +: 7]});
            if (bus.in_data[16*l+7 +: 8] == 8'h00) begin
                // Denormals flush to zero; the sign survives.
                dec_exp[l]  = '0;
                dec_mant[l] = '0;
            end
`ifdef BF16_GATHER_SAT_EN
            else if (bus.in_data[16*l+7 +: 8] == 8'hFF) begin
                dec_exp[l]  = EXPONENT_SIZE'(8'hFE);
                dec_mant[l] = '1;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt      <= '0;
            bus.out_valid <= 1'b0;
            for (int e = 0; e < NUM; e++) begin
                asm_sign[e]         <= 1'b0;
                asm_exp[e]          <= '0;
                asm_mant[e]         <= '0;
                bus.sign_out[e]     <= 1'b0;
                bus.exponent_out[e] <= '0;
                bus.mantissa_out[e] <= '0;
            end
        end else if (completing) begin
            // Earlier beats come from assembly, this beat from the decoders, later slots are padding.
            for (int e = 0; e < NUM; e++) begin
                if (CNT_W'(e / LANES) < beat_cnt) begin
                    bus.sign_out[e]     <= asm_sign[e];
                    bus.exponent_out[e] <= asm_exp[e];
                    bus.mantissa_out[e] <= asm_mant[e];
                end else if (CNT_W'(e / LANES) == beat_cnt) begin
                    bus.sign_out[e]     <= dec_sign[e % LANES];
                    bus.exponent_out[e] <= dec_exp[e % LANES];
                    bus.mantissa_out[e] <= dec_mant[e % LANES];
                end else begin
                    bus.sign_out[e]     <= 1'b0;
                    bus.exponent_out[e] <= '0;
                    bus.mantissa_out[e] <= '0;
                end
                asm_sign[e] <= 1'b0;
                asm_exp[e]  <= '0;
                asm_mant[e] <= '0;
            end
            bus.out_valid <= 1'b1;
            beat_cnt      <= '0;
        end else begin
            if (accept) begin
                for (int e = 0; e < NUM; e++) begin
                    if (CNT_W'(e / LANES) == beat_cnt) begin
                        asm_sign[e] <= dec_sign[e % LANES];
                        asm_exp[e]  <= dec_exp[e % LANES];
                        asm_mant[e] <= dec_mant[e % LANES];
                    end
                end
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
            if (bus.out_valid & bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bf16_block_gather.sv
// Directed scoreboard bench for bf16_block_gather (NUM=10, LANES=2).
module tb_bf16_block_gather;

    localparam int NUM = 10;
    localparam int LANES = 2;
    localparam int EW = 17;
    localparam int BW = NUM * EW;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] beat_cnt;

    int total = 0;
    int bad = 0;

    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] cur_exp = '0;
    logic [BW-1:0] held_a;

    bf16_block_gather_if #(.NUM(NUM), .LANES(LANES), .EXPONENT_SIZE(8), .MANTISSA_SIZE(8)) bus ();

    bf16_block_gather #(.NUM(NUM), .LANES(LANES), .EXPONENT_SIZE(8), .MANTISSA_SIZE(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .beat_cnt (beat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [EW-1:0] el(input logic s, input logic [7:0] e, input logic [7:0] m);
        return {s, e, m};
    endfunction

    function automatic logic [BW-1:0] pack_out();
        logic [BW-1:0] r;
        r = '0;
        for (int e = 0; e < NUM; e++)
            r[e*EW +: EW] = {bus.sign_out[e], bus.exponent_out[e], bus.mantissa_out[e]};
        return r;
    endfunction

    task automatic set_elem(input int e, input logic [EW-1:0] v);
        cur_exp[e*EW +: EW] = v;
    endtask

    task automatic push_exp();
        exp_q.push_back(cur_exp);
        cur_exp = '0;
    endtask

    // Present one beat and hold it until accepted (bounded wait).
    task automatic send_beat(input logic [31:0] d, input logic last);
        int waited;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        @(negedge clk);
        while (!bus.in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        chk("in_ready_wait", BW'(bus.in_ready), BW'(1));
        if (bus.in_ready) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Monitor: every output handshake pops and checks the oldest expected block.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) chk("unexpected_block", BW'(1), BW'(0));
                else chk("block", pack_out(), exp_q.pop_front());
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_out_valid", BW'(bus.out_valid), BW'(0));
        chk("reset_beat_cnt", BW'(beat_cnt), BW'(0));
        chk("reset_in_ready", BW'(bus.in_ready), BW'(1));
        chk("reset_outputs", pack_out(), '0);
        @(posedge clk); #1;

        // 1.0 everywhere, back-to-back, latency check.
        for (int e = 0; e < NUM; e++) set_elem(e, el(1'b0, 8'h7F, 8'h80));
        for (int k = 0; k < 4; k++) send_beat({16'h3F80, 16'h3F80}, 1'b0);
        chk("t1_no_early_valid", BW'(bus.out_valid), BW'(0));
        chk("t1_beat_cnt_4", BW'(beat_cnt), BW'(4));
        push_exp();
        send_beat({16'h3F80, 16'h3F80}, 1'b0);
        chk("t1_valid_after_last", BW'(bus.out_valid), BW'(1));
        chk("t1_beat_cnt_wrap", BW'(beat_cnt), BW'(0));

        // Mixed values: normals, denormal flush, negative zero, max fraction.
        set_elem(0, el(1'b1, 8'h80, 8'hC0));
        set_elem(1, el(1'b0, 8'h00, 8'h00));
        set_elem(2, el(1'b0, 8'h82, 8'hA0));
        set_elem(3, el(1'b0, 8'h7F, 8'h80));
        set_elem(4, el(1'b1, 8'h7F, 8'h80));
        set_elem(5, el(1'b0, 8'h01, 8'h80));
        set_elem(6, el(1'b0, 8'hFE, 8'h80));
        set_elem(7, el(1'b1, 8'h00, 8'h00));
        set_elem(8, el(1'b0, 8'h80, 8'h80));
        set_elem(9, el(1'b0, 8'h7F, 8'hFF));
        send_beat({16'h0001, 16'hC040}, 1'b0);
        send_beat({16'h3F80, 16'h4120}, 1'b0);
        send_beat({16'h0080, 16'hBF80}, 1'b0);
        send_beat({16'h8000, 16'h7F00}, 1'b0);
        push_exp();
        send_beat({16'h3FFF, 16'h4000}, 1'b0);

        // in_last on beat 2: elements 4..9 padded with zero.
        set_elem(0, el(1'b0, 8'h7F, 8'h80));
        set_elem(1, el(1'b0, 8'h82, 8'hA0));
        set_elem(2, el(1'b1, 8'h80, 8'hC0));
        set_elem(3, el(1'b1, 8'h00, 8'h00));
        send_beat({16'h4120, 16'h3F80}, 1'b0);
        push_exp();
        send_beat({16'h8001, 16'hC040}, 1'b1);
        chk("t3_beat_cnt_reset", BW'(beat_cnt), BW'(0));
        chk("t3_valid", BW'(bus.out_valid), BW'(1));

        // in_last on the first beat of a block.
        set_elem(0, el(1'b0, 8'h80, 8'h80));
        set_elem(1, el(1'b0, 8'h01, 8'h80));
        push_exp();
        send_beat({16'h0080, 16'h4000}, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // Stall: block A pending, block B fills, completing beat waits for out_ready.
        bus.out_ready = 1'b0;
        for (int e = 0; e < NUM; e += 2) begin
            set_elem(e, el(1'b0, 8'h7F, 8'h80));
            set_elem(e + 1, el(1'b0, 8'h80, 8'h80));
        end
        held_a = cur_exp;
        for (int k = 0; k < 4; k++) send_beat({16'h4000, 16'h3F80}, 1'b0);
        push_exp();
        send_beat({16'h4000, 16'h3F80}, 1'b0);
        for (int k = 0; k < 4; k++) send_beat({16'hBF80, 16'h0001}, 1'b0);
        chk("t4_b_beats_taken", BW'(beat_cnt), BW'(4));
        bus.in_valid = 1'b1;
        bus.in_data  = {16'hBF80, 16'h0001};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_in_ready_low", BW'(bus.in_ready), BW'(0));
            chk("t4_held_valid", BW'(bus.out_valid), BW'(1));
            chk("t4_held_block", pack_out(), held_a);
        end
        for (int e = 0; e < NUM; e += 2) begin
            set_elem(e, el(1'b0, 8'h00, 8'h00));
            set_elem(e + 1, el(1'b1, 8'h7F, 8'h80));
        end
        push_exp();
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("t5_in_ready_high", BW'(bus.in_ready), BW'(1));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t5_no_gap", BW'(bus.out_valid), BW'(1));
        @(posedge clk); #1;

        // Infinity / NaN handling.
`ifdef BF16_GATHER_SAT_EN
        set_elem(0, el(1'b0, 8'hFE, 8'hFF));
        set_elem(1, el(1'b1, 8'hFE, 8'hFF));
`else
        set_elem(0, el(1'b0, 8'hFF, 8'h80));
        set_elem(1, el(1'b1, 8'hFF, 8'hC1));
`endif
        for (int e = 2; e < NUM; e++) set_elem(e, el(1'b0, 8'h7F, 8'h80));
        send_beat({16'hFFC1, 16'h7F80}, 1'b0);
        for (int k = 0; k < 3; k++) send_beat({16'h3F80, 16'h3F80}, 1'b0);
        push_exp();
        send_beat({16'h3F80, 16'h3F80}, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        // Reset with a block pending and another partially assembled: both discarded.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) send_beat({16'hC040, 16'hC040}, 1'b0);
        send_beat({16'hC040, 16'hC040}, 1'b0);
        send_beat({16'hC040, 16'hC040}, 1'b0);
        rst = 1'b1;
        #2;
        chk("rst_out_valid", BW'(bus.out_valid), BW'(0));
        chk("rst_beat_cnt", BW'(beat_cnt), BW'(0));
        chk("rst_outputs", pack_out(), '0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        for (int e = 0; e < NUM; e += 2) begin
            set_elem(e, el(1'b1, 8'h80, 8'hC0));
            set_elem(e + 1, el(1'b0, 8'h82, 8'hA0));
        end
        for (int k = 0; k < 4; k++) send_beat({16'h4120, 16'hC040}, 1'b0);
        push_exp();
        send_beat({16'h4120, 16'hC040}, 1'b0);

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        chk("queue_drained", BW'(exp_q.size()), BW'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
